// File: rtl/systolic_pkg.sv
// systolic_pkg: shared systolic-array sizing defaults and the weight-feeder state encoding.
// No ports; imported by weight_feeder.
package systolic_pkg;

   localparam int SA_WIDTH      = 16;
   localparam int SA_DATA_WIDTH = 8;
   localparam int SA_IDX_WIDTH  = $clog2(SA_WIDTH);

   typedef enum logic [1:0] {
      FEED_IDLE,
      FEED_LOAD,
      FEED_DRAIN,
      FEED_DONE
   } feeder_state_t;

endpackage

// File: rtl/weight_feeder.sv
// weight_feeder: streams one weight tile row by row onto the array's north edge, tagging every column with its target row.
// Ports: clk/rst (async, active-high); start + num_rows request a tile; in_valid/in_ready/in_data carry weight rows;
//        w_out/idx_out/accept_w_out feed the array columns; busy is high outside IDLE; load_done pulses when the tile has settled.
module weight_feeder
   import systolic_pkg::*;
#(
   parameter int SYSTOLIC_ARRAY_WIDTH = SA_WIDTH,
   parameter int DATA_WIDTH_IN        = SA_DATA_WIDTH,
   parameter int IDX_WIDTH            = $clog2(SYSTOLIC_ARRAY_WIDTH)
)(
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [IDX_WIDTH:0]                        num_rows,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0] in_data,
   output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0] w_out,
   output logic [SYSTOLIC_ARRAY_WIDTH*IDX_WIDTH-1:0]     idx_out,
   output logic [SYSTOLIC_ARRAY_WIDTH-1:0]               accept_w_out,
   output logic                                      busy,
   output logic                                      load_done
);

   localparam int                 W          = SYSTOLIC_ARRAY_WIDTH;
   localparam logic [IDX_WIDTH:0] ROWS_MAX   = (IDX_WIDTH+1)'(W);
   localparam logic [IDX_WIDTH-1:0] DRAIN_LAST = IDX_WIDTH'(W-1);

   feeder_state_t                r_state;
   logic [IDX_WIDTH:0]           r_rows;
   logic [IDX_WIDTH:0]           r_row_cnt;
   logic [IDX_WIDTH-1:0]         r_drain_cnt;
   logic [W*DATA_WIDTH_IN-1:0]   r_w_out;
   logic [W*IDX_WIDTH-1:0]       r_idx_out;
   logic [W-1:0]                 r_accept;
   logic                         r_load_done;
   logic                         w_xfer;
   logic [IDX_WIDTH:0]           w_row_nxt;
   logic [IDX_WIDTH:0]           w_rows_in;

   assign w_xfer    = in_valid && r_state == FEED_LOAD;
   assign w_row_nxt = r_row_cnt + (IDX_WIDTH+1)'(1);
   // Out-of-range tile sizes fall back to a full tile.
   assign w_rows_in = (num_rows == '0 || num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;

   assign in_ready     = r_state == FEED_LOAD;
   assign busy         = r_state != FEED_IDLE;
   assign load_done    = r_load_done;
   assign w_out        = r_w_out;
   assign idx_out      = r_idx_out;
   assign accept_w_out = r_accept;

   // Every column of a row targets the same PE row, so the index is simply replicated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w_out   <= '0;
         r_idx_out <= '0;
         r_accept  <= '0;
      end else begin
         r_w_out   <= w_xfer ? in_data : '0;
         r_idx_out <= w_xfer ? {W{r_row_cnt[IDX_WIDTH-1:0]}} : '0;
         r_accept  <= {W{w_xfer}};
      end
   end

   // DRAIN waits W cycles so the weight tagged for the farthest row has finished hopping down.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= FEED_IDLE;
         r_rows      <= ROWS_MAX;
         r_row_cnt   <= '0;
         r_drain_cnt <= '0;
         r_load_done <= 1'b0;
      end else begin
         r_load_done <= r_state == FEED_DRAIN && r_drain_cnt == DRAIN_LAST;
         case (r_state)
            FEED_IDLE: if (start) begin
               r_rows    <= w_rows_in;
               r_row_cnt <= '0;
               r_state   <= FEED_LOAD;
            end
            FEED_LOAD: if (w_xfer) begin
               r_row_cnt <= w_row_nxt;
               if (w_row_nxt == r_rows) begin
                  r_drain_cnt <= '0;
                  r_state     <= FEED_DRAIN;
               end
            end
            FEED_DRAIN: begin
               r_drain_cnt <= r_drain_cnt + IDX_WIDTH'(1);
               if (r_drain_cnt == DRAIN_LAST) r_state <= FEED_DONE;
            end
            FEED_DONE: r_state <= FEED_IDLE;
            default:   r_state <= FEED_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_feeder.sv
// tb_weight_feeder: scoreboard bench for weight_feeder at W=4, including a shadow 4x4 PE weight array.
module tb_weight_feeder;

   localparam int W  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [IW:0]       num_rows = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [W*DW-1:0]   in_data = '0;
   logic [W*DW-1:0]   w_out;
   logic [W*IW-1:0]   idx_out;
   logic [W-1:0]      accept_w_out;
   logic              busy;
   logic              load_done;

   typedef struct packed {
      logic [W*DW-1:0] w;
      logic [W*IW-1:0] idx;
   } exp_t;

   exp_t            q[$];
   exp_t            e;
   int              n_checks = 0;
   int              n_pass = 0;
   int              dones = 0;
   logic [DW-1:0]   pe [W][W];
   logic [W*DW-1:0] tile_rows [W];

   weight_feeder #(.SYSTOLIC_ARRAY_WIDTH(W), .DATA_WIDTH_IN(DW), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .w_out(w_out), .idx_out(idx_out), .accept_w_out(accept_w_out),
      .busy(busy), .load_done(load_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (load_done) dones++;
      if (accept_w_out != '0) begin
         for (int c = 0; c < W; c++)
            if (accept_w_out[c]) pe[idx_out[c*IW +: IW]][c] = w_out[c*DW +: DW];
         if (q.size() == 0) check("extra_accept", 64'(accept_w_out), 64'd0);
         else begin
            e = q.pop_front();
            check("accept", 64'(accept_w_out), 64'hF);
            check("w_out", 64'(w_out), 64'(e.w));
            check("idx_out", 64'(idx_out), 64'(e.idx));
         end
      end else check("idle_zero", 64'({w_out, idx_out}), 64'd0);
   end

   task automatic load_tile(input int n_req, input int n_eff, input logic [6:0] pat,
                            input bit start_in_load, input bit start_in_done, input bit keep_valid);
      int sent = 0;
      int k = 0;
      int cyc = 1;
      int d0;
      logic v;
      logic [W*DW-1:0] row;
      @(negedge clk);
      d0 = dones;
      start = 1'b1;
      num_rows = n_req[IW:0];
      @(negedge clk);
      start = 1'b0;
      check("busy_load", 64'(busy), 64'd1);
      while (sent < n_eff) begin
         check("in_ready_load", 64'(in_ready), 64'd1);
         v = k < 7 ? pat[6-k] : 1'b1;
         k++;
         row = $urandom;
         in_valid = v;
         in_data = row;
         start = start_in_load && k == 2;
         num_rows = start_in_load ? 3'd1 : num_rows;
         if (v) begin
            q.push_back({row, {W{sent[IW-1:0]}}});
            tile_rows[sent] = row;
            sent++;
         end
         @(negedge clk);
      end
      in_valid = keep_valid;
      start = 1'b0;
      check("in_ready_drain", 64'(in_ready), 64'd0);
      while (!load_done && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      check("done_latency", 64'(cyc), 64'd5);
      check("busy_done", 64'(busy), 64'd1);
      if (start_in_done) begin
         start = 1'b1;
         num_rows = 3'd1;
      end
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      check("busy_idle", 64'(busy), 64'd0);
      check("done_pulse_len", 64'(load_done), 64'd0);
      @(negedge clk);
      check("busy_idle2", 64'(busy), 64'd0);
      check("done_count", 64'(dones - d0), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0;
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_load_done", 64'(load_done), 64'd0);
      check("rst_outputs", 64'({accept_w_out, w_out, idx_out}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      load_tile(4, 4, 7'b1111111, 0, 0, 0);
      for (int r = 0; r < W; r++)
         for (int c = 0; c < W; c++)
            check($sformatf("pe_%0d_%0d", r, c), 64'(pe[r][c]), 64'(tile_rows[r][c*DW +: DW]));
      load_tile(4, 4, 7'b1001101, 0, 0, 0);
      load_tile(2, 2, 7'b1111111, 0, 0, 1);
      load_tile(0, 4, 7'b1111111, 0, 0, 0);
      load_tile(7, 4, 7'b1101111, 0, 0, 0);
      load_tile(4, 4, 7'b1111111, 1, 1, 0);
      @(negedge clk);
      d0 = dones;
      start = 1'b1;
      num_rows = 3'd4;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data = $urandom;
         q.push_back({in_data, {W{2'(i)}}});
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_outputs", 64'({accept_w_out, w_out, idx_out}), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 8; i++) @(negedge clk);
      check("arst_no_done", 64'(dones - d0), 64'd0);
      rst = 1'b0;
      load_tile(3, 3, 7'b1111111, 0, 0, 0);
      check("sb_empty", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/weight_feeder.md
WEIGHT_FEEDER -- requirements
Module: weight_feeder

Interface
REQ-001 SHALL have parameter SYSTOLIC_ARRAY_WIDTH, default 16: array rows/columns (W).
REQ-002 SHALL have parameter DATA_WIDTH_IN, default 8: signed weight width.
REQ-003 SHALL have parameter IDX_WIDTH, default $clog2(SYSTOLIC_ARRAY_WIDTH): row index width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle request to load one weight tile.
REQ-007 num_rows  input  IDX_WIDTH+1  rows in the tile (1..W), sampled on accepted start.
REQ-008 in_valid  input  1  source has a weight row on in_data.
REQ-009 in_ready  output  1  feeder accepts a row this cycle.
REQ-010 in_data  input  W*DATA_WIDTH_IN  one weight row; slice c is the weight for column c.
REQ-011 w_out  output  W*DATA_WIDTH_IN  per-column weight to the array's north edge.
REQ-012 idx_out  output  W*IDX_WIDTH  per-column target row index.
REQ-013 accept_w_out  output  W  per-column weight-valid strobe.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 load_done  output  1  one-cycle pulse when the last weight has reached its PE row.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-017 IDLE -> LOAD when start=1; num_rows latched; row counter cleared to 0.
REQ-018 start SHALL be ignored in any state other than IDLE.
REQ-019 num_rows of 0 or greater than W SHALL be clamped to W when latched.
REQ-020 in_ready SHALL be 1 only in LOAD; transfer occurs when in_valid and in_ready are both 1.
REQ-021 On a transfer with row counter r, the next cycle SHALL present, for every column c: w_out[c]=in_data[c], idx_out[c]=r, accept_w_out[c]=1 (registered, latency 1).
REQ-022 In any cycle without a transfer, accept_w_out SHALL be all 0 and w_out/idx_out SHALL be 0.
REQ-023 The row counter SHALL increment by 1 per transfer; the transfer of row num_rows-1 SHALL move LOAD -> DRAIN.
REQ-024 In LOAD, in_valid gaps SHALL stall without limit and SHALL NOT change the row counter.
REQ-025 DRAIN SHALL last exactly W cycles, covering the worst-case hop delay to row W-1; it then moves to DONE.
REQ-026 DONE SHALL last one cycle with load_done=1, then move to IDLE.
REQ-027 busy SHALL be 0 in IDLE and 1 in LOAD, DRAIN and DONE.
REQ-028 A start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-029 The feeder SHALL NOT drive the switch signal; the controller issues it after load_done.

Reset
REQ-030 While rst=1: state=IDLE, row counter=0, drain counter=0, latched num_rows=W.
REQ-031 While rst=1: in_ready=0, busy=0, load_done=0, accept_w_out=0, w_out=0, idx_out=0.
REQ-032 rst asserted mid-LOAD or mid-DRAIN SHALL abort the load immediately with no load_done pulse.

Structure
REQ-033 W, DATA_WIDTH_IN and IDX_WIDTH defaults, plus the feeder state enum, SHALL live in shared package systolic_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; output registers, row counter and drain counter are inline.

Verification (W=4)
REQ-035 Full tile: start with num_rows=4, rows {1,2,3,4}x4 with in_valid held 1 -> idx_out 0,1,2,3 on four consecutive cycles with accept_w_out=4'b1111; w_out matches each row; load_done exactly 4 cycles after the last accept.
REQ-036 Stalls: in_valid toggles 1,0,0,1,1,0,1 -> accept_w_out high only the cycle after each transfer; idx_out sequence is 0..3 with no skipped or repeated index.
REQ-037 Partial tile: num_rows=2 -> exactly two accepts with idx 0 and 1; DRAIN is 4 cycles; num_rows=0 behaves as 4.
REQ-038 Reset mid-load: rst asserted after the second accepted row -> all outputs 0 asynchronously, no load_done; the next start reloads from idx 0.
REQ-039 Start while busy: start pulsed in LOAD and in DONE -> ignored; exactly one load_done per accepted start.
REQ-040 Array integration: feeder drives a 4x4 PE array, then switch is issued -> each PE's active weight equals in_data[row r][column c].
